// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and generator FSM encoding.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH     = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SAFE_SEED = 32'h0000_0001;
  localparam int unsigned BURST_CNT_W    = 16;
  localparam int unsigned WORDS_SENT_W   = 32;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_RUN,
    GEN_DONE
  } lfsr_gen_state_t;

endpackage : lfsr_pkg

// File: rtl/lfsr.sv
// LFSR next-state function (Galois form, x^32 + x^22 + x^2 + x + 1).
// Shared by generator and checker so both ends agree on the polynomial.
module lfsr #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(32'h0040_0007)
) (
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  // Shift toward the MSB and fold the bit that leaves back in through the taps.
  always_comb begin
    dataout = {datain[WIDTH-2:0], 1'b0} ^ ({WIDTH{datain[WIDTH-1]}} & POLY);
  end

endmodule : lfsr

// File: rtl/lfsr_generator.sv
// Pseudo-random word source: valid/ready stream of successive LFSR states,
// with seed load, bounded or free-running bursts and one-shot error injection.
module lfsr_generator
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h0000_0001)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed,
  input  logic                    start,
  input  logic [BURST_CNT_W-1:0]  count,
  input  logic                    stop,
  input  logic                    inject_err,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    busy,
  output logic                    done,
  output logic [WORDS_SENT_W-1:0] words_sent
);

  // An all-zero state would lock the LFSR, so it is never allowed in.
  localparam logic [WIDTH-1:0] SAFE_SEED  = WIDTH'(LFSR_SAFE_SEED);
  localparam logic [WIDTH-1:0] RESET_SEED = (DEFAULT_SEED == '0) ? SAFE_SEED : DEFAULT_SEED;

  lfsr_gen_state_t         fsm_q, fsm_d;
  logic [WIDTH-1:0]        state_q, state_d, state_nxt;
  logic                    inj_pend_q, inj_pend_d;
  logic [BURST_CNT_W-1:0]  count_q, count_d;
  logic [BURST_CNT_W-1:0]  burst_q, burst_d;
  logic [WORDS_SENT_W-1:0] sent_d;
  logic                    xfer_c;

  lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .datain  (state_q),
    .dataout (state_nxt)
  );

  // dout_valid is high exactly while in RUN, so it qualifies the handshake.
  assign xfer_c = dout_valid & dout_ready;

  // FSM, sequence state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= GEN_IDLE;
      state_q    <= RESET_SEED;
      inj_pend_q <= 1'b0;
      count_q    <= '0;
      burst_q    <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      inj_pend_q <= inj_pend_d;
      count_q    <= count_d;
      burst_q    <= burst_d;
    end
  end

  // Next-state logic; the LFSR advances from the uncorrupted state.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    inj_pend_d = inject_err | (inj_pend_q & ~xfer_c);
    count_d    = count_q;
    burst_d    = burst_q;
    sent_d     = words_sent;
    unique case (fsm_q)
      GEN_IDLE: begin
        if (seed_load) begin
          state_d = (seed == '0) ? SAFE_SEED : seed;
        end
        if (start) begin
          fsm_d   = GEN_RUN;
          count_d = count;
          burst_d = '0;
          sent_d  = '0;
        end
      end
      GEN_RUN: begin
        if (xfer_c) begin
          state_d = state_nxt;
          burst_d = burst_q + BURST_CNT_W'(1);
          sent_d  = words_sent + WORDS_SENT_W'(1);
        end
        if (stop) begin
          fsm_d = GEN_IDLE;
        end else if (xfer_c && (count_q != '0) && (burst_d == count_q)) begin
          fsm_d = GEN_DONE;
        end
      end
      GEN_DONE: begin
        fsm_d = GEN_IDLE;
      end
      default: begin
        fsm_d = GEN_IDLE;
      end
    endcase
  end

  // Registered outputs, loaded from the next-state values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout       <= RESET_SEED;
      words_sent <= '0;
    end else begin
      dout_valid <= (fsm_d == GEN_RUN);
      busy       <= (fsm_d != GEN_IDLE);
      done       <= (fsm_d == GEN_DONE);
      dout       <= state_d ^ {{(WIDTH-1){1'b0}}, inj_pend_d};
      words_sent <= sent_d;
    end
  end

endmodule : lfsr_generator

// File: tb/tb_lfsr_generator.sv
// Self-checking bench for lfsr_generator: cycle model plus a loopback checker.
module tb_lfsr_generator;

  localparam logic [31:0] POLY_LOW = 32'h0040_0007; // p(x) = x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] DEF_SEED = 32'h0000_0001;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic        stop = 1'b0;
  logic        inject_err = 1'b0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;

  lfsr_generator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .start      (start),
    .count      (count),
    .stop       (stop),
    .inject_err (inject_err),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;

  // Reference model state
  int          m_phase;
  logic [31:0] m_state;
  logic        m_pend;
  logic [31:0] m_sent;
  int          m_left;
  bit          m_free;

  // Loopback checker state
  logic [31:0] chk_prev;
  bit          chk_has;
  int          chk_err = 0;

  // Multiply by x in GF(2)[x] modulo p(x).
  function automatic logic [31:0] lfsr_ref(input logic [31:0] w);
    logic [32:0] p;
    p = {w, 1'b0};
    if (p[32]) p = p ^ {1'b1, POLY_LOW};
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_state = DEF_SEED;
    m_pend  = 1'b0;
    m_sent  = '0;
    m_left  = 0;
    m_free  = 1'b0;
    chk_has = 1'b0;
  endtask

  // One clock: drive at negedge, update model, compare just after posedge.
  task automatic step(input bit ld, input logic [31:0] sd, input bit st, input logic [15:0] cnt,
                      input bit sp, input bit inj, input bit rdy);
    bit xfer;
    @(negedge clk);
    seed_load = ld; seed = sd; start = st; count = cnt;
    stop = sp; inject_err = inj; dout_ready = rdy;

    if (m_phase == PH_IDLE && ld) chk_has = 1'b0;
    if (dout_valid && rdy) begin
      if (chk_has && dout !== lfsr_ref(chk_prev)) chk_err++;
      chk_prev = dout;
      chk_has  = 1'b1;
    end

    xfer = (m_phase == PH_RUN) && rdy;
    case (m_phase)
      PH_IDLE: begin
        if (ld) m_state = (sd == 0) ? 32'h1 : sd;
        if (st) begin
          m_phase = PH_RUN; m_sent = 0; m_left = int'(cnt); m_free = (cnt == 0);
        end
      end
      PH_RUN: begin
        if (xfer) begin
          m_state = lfsr_ref(m_state);
          m_sent  = m_sent + 1;
          if (!m_free) m_left--;
        end
        if (sp) m_phase = PH_IDLE;
        else if (xfer && !m_free && m_left == 0) m_phase = PH_DONE;
      end
      default: m_phase = PH_IDLE;
    endcase
    m_pend = inj | (m_pend & ~xfer);

    @(posedge clk);
    #1;
    check("dout_valid", 32'(dout_valid), 32'(m_phase == PH_RUN));
    check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    check("done", 32'(done), 32'(m_phase == PH_DONE));
    check("dout", dout, m_state ^ {31'b0, m_pend});
    check("words_sent", words_sent, m_sent);
  endtask

  task automatic run_steps(input int n, input bit rand_rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1);
  endtask

  // Finish an active bounded burst; running out of budget is a failure.
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (m_phase != PH_IDLE && k < budget) begin
      step(0, 0, 0, 0, 0, 0, bit'($urandom_range(0, 1)));
      k++;
    end
    check("drain_timeout", 32'(m_phase == PH_IDLE), 32'd1);
  endtask

  logic [31:0] seed_a, ref3;
  int          err0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_dout", dout, DEF_SEED);
    check("rst_sent", words_sent, 32'd0);

    // Seeded bounded burst of 4
    step(1, 32'h1234_5678, 1, 16'd4, 0, 0, 1);
    check("first_word", dout, 32'h1234_5678);
    run_steps(4, 0);
    check("done_pulse", 32'(done), 32'd1);
    check("burst4_sent", words_sent, 32'd4);
    step(0, 0, 0, 0, 0, 0, 1);
    check("after_done_idle", 32'(busy), 32'd0);

    // Free-run with random stalls, stop with transfer, contiguous restart
    step(0, 0, 1, 16'd0, 0, 0, 1);
    run_steps(150, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    check("stop_valid_low", 32'(dout_valid), 32'd0);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 16'd0, 1, 0, 1);
    run_steps(50, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    check("free_run_chk", 32'(chk_err), 32'd0);

    // Error injection on the 3rd word
    seed_a = 32'hCAFE_F00D;
    step(1, seed_a, 1, 16'd6, 0, 0, 1);
    err0 = chk_err;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    ref3 = lfsr_ref(lfsr_ref(seed_a));
    check("inj_word3", dout, ref3 ^ 32'h1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("inj_word4", dout, lfsr_ref(ref3));
    drain(20);
    check("inj_chk_errors", 32'(chk_err - err0), 32'd2);

    // Zero seed, then ignored seed_load/start during RUN
    step(1, 32'h0, 1, 16'd0, 0, 0, 0);
    check("zero_seed", dout, 32'h1);
    err0 = chk_err;
    for (int i = 0; i < 30; i++)
      step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)), 16'($urandom),
           0, 0, bit'($urandom_range(0, 1)));
    step(0, 0, 0, 0, 1, 0, 0);
    check("ignored_chk", 32'(chk_err - err0), 32'd0);

    // Random bounded bursts with stop sometimes ignored in IDLE
    for (int b = 0; b < 4; b++) begin
      step(0, 0, 1, 16'($urandom_range(1, 12)), bit'($urandom_range(0, 1)), 0, 1);
      drain(100);
    end

    // Asynchronous reset mid-burst
    step(0, 0, 1, 16'd0, 0, 0, 1);
    run_steps(10, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sent", words_sent, 32'd0);
    model_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    step(0, 0, 1, 16'd3, 0, 0, 1);
    check("arst_first_word", dout, DEF_SEED);
    drain(20);

    // Loopback over 10000 words with random ready
    err0 = chk_err;
    step(0, 0, 1, 16'd0, 0, 0, 0);
    for (int i = 0; i < 40000 && m_sent < 32'd10000; i++)
      step(0, 0, 0, 0, 0, 0, bit'($urandom_range(0, 1)));
    step(0, 0, 0, 0, 1, 0, 0);
    check("loop_words", words_sent, 32'd10000);
    check("loop_chk_errors", 32'(chk_err - err0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_lfsr_generator
